// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port round-robin arbiter and sequencer for the data memory
// One request in flight; illegal requests are answered with err and never touch memory.
module dmem_arbiter #(
  parameter logic [31:0] BASE_ADDR = 32'h01000000,
  parameter logic [31:0] MEM_BYTES = 32'h00010000
) (
  input  logic        clock,
  input  logic        reset,

  input  logic        p0_req_valid,
  output logic        p0_req_ready,
  input  logic [31:0] p0_addr,
  input  logic [31:0] p0_wdata,
  input  logic        p0_write,
  input  logic [2:0]  p0_size,
  output logic        p0_rsp_valid,
  output logic [31:0] p0_rsp_rdata,
  output logic        p0_rsp_err,

  input  logic        p1_req_valid,
  output logic        p1_req_ready,
  input  logic [31:0] p1_addr,
  input  logic [31:0] p1_wdata,
  input  logic        p1_write,
  input  logic [2:0]  p1_size,
  output logic        p1_rsp_valid,
  output logic [31:0] p1_rsp_rdata,
  output logic        p1_rsp_err,

  output logic [31:0] mem_address,
  output logic [31:0] mem_data_in,
  output logic        mem_read_write,
  output logic [2:0]  mem_access_size,
  input  logic [31:0] mem_data_out,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  // 33-bit so BASE_ADDR+MEM_BYTES-1 cannot wrap
  localparam logic [32:0] FIRST_BYTE = {1'b0, BASE_ADDR};
  localparam logic [32:0] LAST_BYTE  = {1'b0, BASE_ADDR} + {1'b0, MEM_BYTES} - 33'd1;

  state_t      state, state_next;
  logic        last_grant;
  logic        grant_valid, grant_port;

  logic [31:0] sel_addr, sel_wdata;
  logic        sel_write;
  logic [2:0]  sel_size;
  logic [2:0]  sel_bytes;
  logic        sel_aligned, sel_legal;
  logic [32:0] sel_lo, sel_hi;

  logic [31:0] addr_q, wdata_q, rdata_q;
  logic        write_q, port_q, err_q;
  logic [2:0]  size_q;

  always_comb begin
    grant_valid = (state == IDLE) && (p0_req_valid || p1_req_valid);
    grant_port  = p1_req_valid && (!p0_req_valid || !last_grant);
  end

  always_comb begin
    sel_addr  = grant_port ? p1_addr  : p0_addr;
    sel_wdata = grant_port ? p1_wdata : p0_wdata;
    sel_write = grant_port ? p1_write : p0_write;
    sel_size  = grant_port ? p1_size  : p0_size;
    case (sel_size[1:0])
      2'b00:   begin sel_bytes = 3'd1; sel_aligned = 1'b1; end
      2'b01:   begin sel_bytes = 3'd2; sel_aligned = (sel_addr[0] == 1'b0); end
      2'b10:   begin sel_bytes = 3'd4; sel_aligned = (sel_addr[1:0] == 2'b00); end
      default: begin sel_bytes = 3'd4; sel_aligned = 1'b0; end
    endcase
    sel_lo    = {1'b0, sel_addr};
    sel_hi    = sel_lo + {30'b0, sel_bytes} - 33'd1;
    sel_legal = sel_aligned && (sel_lo >= FIRST_BYTE) && (sel_hi <= LAST_BYTE);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (grant_valid) state_next = sel_legal ? ACCESS : RESP;
      ACCESS:  state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      last_grant <= 1'b1;
      addr_q     <= BASE_ADDR;
      wdata_q    <= 32'h0;
      write_q    <= 1'b0;
      size_q     <= 3'b010;
      port_q     <= 1'b0;
      err_q      <= 1'b0;
      rdata_q    <= 32'h0;
    end else if (grant_valid) begin
      last_grant <= grant_port;
      addr_q     <= sel_addr;
      wdata_q    <= sel_wdata;
      write_q    <= sel_write;
      size_q     <= sel_size;
      port_q     <= grant_port;
      err_q      <= !sel_legal;
      rdata_q    <= 32'h0;
    end else if (state == ACCESS && !write_q) begin
      rdata_q    <= mem_data_out;
    end
  end

  always_comb begin
    p0_req_ready    = grant_valid && !grant_port;
    p1_req_ready    = grant_valid && grant_port;
    p0_rsp_valid    = 1'b0;
    p0_rsp_rdata    = 32'h0;
    p0_rsp_err      = 1'b0;
    p1_rsp_valid    = 1'b0;
    p1_rsp_rdata    = 32'h0;
    p1_rsp_err      = 1'b0;
    mem_address     = BASE_ADDR;
    mem_data_in     = 32'h0;
    mem_read_write  = 1'b0;
    mem_access_size = 3'b010;
    busy            = (state != IDLE);
    case (state)
      ACCESS: begin
        mem_address     = addr_q;
        mem_data_in     = wdata_q;
        mem_read_write  = write_q;
        mem_access_size = size_q;
      end
      RESP: begin
        if (port_q) begin
          p1_rsp_valid = 1'b1;
          p1_rsp_rdata = rdata_q;
          p1_rsp_err   = err_q;
        end else begin
          p0_rsp_valid = 1'b1;
          p0_rsp_rdata = rdata_q;
          p0_rsp_err   = err_q;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - randomized self-checking bench for dmem_arbiter
module tb_dmem_arbiter;
  localparam logic [31:0] BASE = 32'h01000000;
  localparam logic [31:0] MEMB = 32'h00010000;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic [1:0]       req_valid, req_ready, rsp_valid, rsp_err, wr;
  logic [1:0][31:0] addr, wdata, rsp_rdata;
  logic [1:0][2:0]  sz;
  logic [31:0]      mem_address, mem_data_in, mem_data_out;
  logic             mem_read_write, busy;
  logic [2:0]       mem_access_size;

  int n_checks = 0;
  int n_pass   = 0;

  dmem_arbiter #(.BASE_ADDR(BASE), .MEM_BYTES(MEMB)) dut (
    .clock(clock), .reset(reset),
    .p0_req_valid(req_valid[0]), .p0_req_ready(req_ready[0]), .p0_addr(addr[0]),
    .p0_wdata(wdata[0]), .p0_write(wr[0]), .p0_size(sz[0]),
    .p0_rsp_valid(rsp_valid[0]), .p0_rsp_rdata(rsp_rdata[0]), .p0_rsp_err(rsp_err[0]),
    .p1_req_valid(req_valid[1]), .p1_req_ready(req_ready[1]), .p1_addr(addr[1]),
    .p1_wdata(wdata[1]), .p1_write(wr[1]), .p1_size(sz[1]),
    .p1_rsp_valid(rsp_valid[1]), .p1_rsp_rdata(rsp_rdata[1]), .p1_rsp_err(rsp_err[1]),
    .mem_address(mem_address), .mem_data_in(mem_data_in), .mem_read_write(mem_read_write),
    .mem_access_size(mem_access_size), .mem_data_out(mem_data_out), .busy(busy)
  );

  // Little-endian byte memory with combinational, size-aware read
  logic [7:0]  env_mem [0:65535];
  logic [15:0] midx;
  logic [7:0]  mb0, mb1, mb2, mb3;
  always_comb begin
    midx = 16'(mem_address - BASE);
    mb0 = env_mem[midx];
    mb1 = env_mem[midx + 16'd1];
    mb2 = env_mem[midx + 16'd2];
    mb3 = env_mem[midx + 16'd3];
    case (mem_access_size[1:0])
      2'b00:   mem_data_out = mem_access_size[2] ? {24'h0, mb0} : {{24{mb0[7]}}, mb0};
      2'b01:   mem_data_out = mem_access_size[2] ? {16'h0, mb1, mb0} : {{16{mb1[7]}}, mb1, mb0};
      default: mem_data_out = {mb3, mb2, mb1, mb0};
    endcase
  end
  always @(posedge clock) begin
    if (mem_read_write) begin
      env_mem[midx] <= mem_data_in[7:0];
      if (mem_access_size[1:0] != 2'b00) env_mem[midx + 16'd1] <= mem_data_in[15:8];
      if (mem_access_size[1] == 1'b1) begin
        env_mem[midx + 16'd2] <= mem_data_in[23:16];
        env_mem[midx + 16'd3] <= mem_data_in[31:24];
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
  endtask

  // Reference model
  logic [7:0] ref_mem [0:65535];

  function automatic bit ref_legal(input logic [31:0] a, input logic [2:0] s);
    longint la = longint'({32'h0, a});
    int n;
    if (s[1:0] == 2'b11) return 1'b0;
    n = 1 << s[1:0];
    if (la % n != 0) return 1'b0;
    return (la >= longint'({32'h0, BASE})) && (la + n <= longint'({32'h0, BASE}) + longint'({32'h0, MEMB}));
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [2:0] s);
    longint v = 0;
    int n = 1 << s[1:0];
    for (int i = 0; i < n; i++)
      v += longint'(ref_mem[16'(a - BASE + 32'(i))]) << (8 * i);
    if (!s[2] && v >= (longint'(1) << (8 * n - 1))) v -= longint'(1) << (8 * n);
    return v[31:0];
  endfunction

  typedef struct { int due; int port; logic [31:0] rdata; logic err; } exp_t;
  exp_t expq[$];
  int   grant_log[$];

  initial begin : monitor
    int cyc, busy_until, acc_cyc, last, p;
    bit idle, e0, e1, ev;
    logic [31:0] acc_addr, acc_wdata;
    logic        acc_write;
    logic [2:0]  acc_size;
    exp_t e;
    cyc = 0; busy_until = -1; acc_cyc = -1; last = 1;
    acc_addr = '0; acc_wdata = '0; acc_write = 1'b0; acc_size = '0;
    forever begin
      @(negedge clock);
      cyc++;
      if (reset) begin
        expq.delete();
        busy_until = cyc; acc_cyc = -1; last = 1;
      end else begin
        idle = cyc > busy_until;
        e0 = idle && req_valid[0] && (!req_valid[1] || last == 1);
        e1 = idle && req_valid[1] && !e0;
        check("ready0", 32'(req_ready[0]), 32'(e0));
        check("ready1", 32'(req_ready[1]), 32'(e1));
        check("busy", 32'(busy), 32'(!idle));
        if (cyc == acc_cyc) begin
          check("mem_address", mem_address, acc_addr);
          check("mem_data_in", mem_data_in, acc_wdata);
          check("mem_size", 32'(mem_access_size), 32'(acc_size));
          check("mem_rw", 32'(mem_read_write), 32'(acc_write));
          if (acc_write)
            for (int i = 0; i < (1 << acc_size[1:0]); i++)
              ref_mem[16'(acc_addr - BASE + 32'(i))] = 8'(acc_wdata >> (8 * i));
        end else begin
          check("mem_address_idle", mem_address, BASE);
          check("mem_rw_idle", 32'(mem_read_write), 32'd0);
          check("mem_size_idle", 32'(mem_access_size), 32'd2);
        end
        for (int q = 0; q < 2; q++) begin
          ev = expq.size() > 0 && expq[0].due == cyc && expq[0].port == q;
          check($sformatf("rsp_valid%0d", q), 32'(rsp_valid[q]), 32'(ev));
          if (ev) begin
            check($sformatf("rsp_rdata%0d", q), rsp_rdata[q], expq[0].rdata);
            check($sformatf("rsp_err%0d", q), 32'(rsp_err[q]), 32'(expq[0].err));
          end
        end
        if (expq.size() > 0 && expq[0].due <= cyc) void'(expq.pop_front());
        if (e0 || e1) begin
          p = e1 ? 1 : 0;
          last = p;
          grant_log.push_back(p);
          e.port = p;
          if (ref_legal(addr[p], sz[p])) begin
            acc_cyc = cyc + 1; busy_until = cyc + 2;
            acc_addr = addr[p]; acc_wdata = wdata[p]; acc_write = wr[p]; acc_size = sz[p];
            e.due = cyc + 2; e.err = 1'b0;
            e.rdata = wr[p] ? 32'h0 : ref_load(addr[p], sz[p]);
          end else begin
            busy_until = cyc + 1;
            e.due = cyc + 1; e.err = 1'b1; e.rdata = 32'h0;
          end
          expq.push_back(e);
        end
      end
    end
  end

  // Call just after a rising edge; returns just after the accepting edge
  task automatic drive(input int p, input logic [31:0] a, input logic [31:0] d,
                       input logic w, input logic [2:0] s);
    int n = 0;
    addr[p] = a; wdata[p] = d; wr[p] = w; sz[p] = s; req_valid[p] = 1'b1;
    do begin @(negedge clock); n++; end while (!req_ready[p] && n < 200);
    if (!req_ready[p]) check("grant_timeout", 32'd0, 32'd1);
    @(posedge clock); #1;
    req_valid[p] = 1'b0;
  endtask

  task automatic txn(input int p, input logic [31:0] a, input logic [31:0] d, input logic w,
                     input logic [2:0] s, output logic [31:0] rd, output logic er);
    int n = 0;
    bit found = 0;
    rd = 32'h0; er = 1'b0;
    drive(p, a, d, w, s);
    while (!found && n < 10) begin
      @(negedge clock); n++;
      if (rsp_valid[p]) begin found = 1; rd = rsp_rdata[p]; er = rsp_err[p]; end
    end
    if (!found) check("rsp_timeout", 32'd0, 32'd1);
    @(posedge clock); #1;
  endtask

  task automatic rand_port(input int p);
    logic [31:0] a;
    logic [2:0]  s;
    int k, g;
    for (int i = 0; i < 40; i++) begin
      s = 3'($urandom_range(0, 7));
      k = $urandom_range(0, 9);
      if (k == 0)      a = BASE - 32'($urandom_range(1, 8));
      else if (k == 1) a = BASE + MEMB - 32'($urandom_range(1, 8));
      else             a = BASE + 32'($urandom_range(0, 63));
      if (k >= 2 && k <= 7) a = a & ~32'((1 << s[1:0]) - 1);
      drive(p, a, $urandom, 1'($urandom_range(0, 1)), s);
      g = $urandom_range(0, 3);
      repeat (g) @(posedge clock);
      if (g > 0) #1;
    end
  endtask

  task automatic expect_error(input string tag, input logic [31:0] a, input logic w, input logic [2:0] s);
    logic [31:0] rd;
    logic er;
    txn(0, a, 32'h5A5A5A5A, w, s, rd, er);
    check({tag, "_err"}, 32'(er), 32'd1);
    check({tag, "_rdata"}, rd, 32'h0);
  endtask

  initial begin : main
    logic [31:0] rd;
    logic er;
    for (int i = 0; i < 65536; i++) begin
      env_mem[i] = 8'(i * 7 + 3);
      ref_mem[i] = 8'(i * 7 + 3);
    end
    req_valid = '0; addr = '0; wdata = '0; wr = '0; sz = '0;
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_err", 32'(rsp_err), 32'd0);
    check("rst_rdata0", rsp_rdata[0], 32'h0);
    check("rst_rdata1", rsp_rdata[1], 32'h0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_mem_rw", 32'(mem_read_write), 32'd0);
    check("rst_mem_address", mem_address, BASE);
    check("rst_mem_data_in", mem_data_in, 32'h0);
    check("rst_mem_size", 32'(mem_access_size), 32'd2);
    reset = 1'b0;

    txn(0, BASE + 32'h10, 32'hDEADBEEF, 1'b1, 3'b010, rd, er);
    check("st_err", 32'(er), 32'd0);
    check("st_rdata", rd, 32'h0);
    txn(0, BASE + 32'h10, 32'h0, 1'b0, 3'b010, rd, er);
    check("ld_word", rd, 32'hDEADBEEF);
    check("ld_word_err", 32'(er), 32'd0);
    txn(1, BASE + 32'h13, 32'h0, 1'b0, 3'b000, rd, er);
    check("ld_byte_s", rd, 32'hFFFFFFDE);
    txn(1, BASE + 32'h13, 32'h0, 1'b0, 3'b100, rd, er);
    check("ld_byte_z", rd, 32'h000000DE);
    txn(1, BASE + 32'h12, 32'h0, 1'b0, 3'b001, rd, er);
    check("ld_half_s", rd, 32'hFFFFDEAD);

    grant_log.delete();
    fork
      for (int i = 0; i < 4; i++) drive(0, BASE + 32'h40 + 32'(4 * i), 32'h0, 1'b0, 3'b010);
      for (int i = 0; i < 4; i++) drive(1, BASE + 32'h80 + 32'(4 * i), 32'h0, 1'b0, 3'b010);
    join
    repeat (4) @(posedge clock);
    #1;
    check("rr_count", 32'(grant_log.size()), 32'd8);
    for (int i = 0; i < 8 && i < grant_log.size(); i++)
      check($sformatf("rr_grant%0d", i), 32'(grant_log[i]), 32'(i % 2));

    expect_error("mis_word", BASE + 32'h2, 1'b0, 3'b010);
    expect_error("mis_half_st", BASE + 32'h1, 1'b1, 3'b001);
    expect_error("below_base", 32'h00FFFFFC, 1'b0, 3'b010);
    expect_error("past_top", BASE + MEMB - 32'd2, 1'b0, 3'b010);
    expect_error("size_11", BASE, 1'b0, 3'b011);

    txn(0, BASE + MEMB - 32'd4, 32'h12345678, 1'b1, 3'b010, rd, er);
    check("top_st_err", 32'(er), 32'd0);
    txn(0, BASE + MEMB - 32'd4, 32'h0, 1'b0, 3'b010, rd, er);
    check("top_ld", rd, 32'h12345678);
    check("top_ld_err", 32'(er), 32'd0);

    drive(0, BASE + 32'h20, 32'hCAFEF00D, 1'b1, 3'b010);
    check("abort_we_before", 32'(mem_read_write), 32'd1);
    reset = 1'b1;
    #1;
    check("abort_mem_rw", 32'(mem_read_write), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_mem_address", mem_address, BASE);
    check("abort_mem_data_in", mem_data_in, 32'h0);
    check("abort_mem_size", 32'(mem_access_size), 32'd2);
    check("abort_rsp_valid", 32'(rsp_valid), 32'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    grant_log.delete();
    fork
      drive(0, BASE + 32'h20, 32'h0, 1'b0, 3'b010);
      drive(1, BASE + 32'h24, 32'h0, 1'b0, 3'b010);
    join
    repeat (4) @(posedge clock);
    #1;
    check("abort_tie_first", 32'(grant_log.size() > 0 ? grant_log[0] : 9), 32'd0);
    txn(1, BASE + 32'h20, 32'h0, 1'b0, 3'b010, rd, er);
    check("abort_no_write", rd, ref_load(BASE + 32'h20, 3'b010));

    fork
      rand_port(0);
      rand_port(1);
    join
    repeat (6) @(posedge clock);
    #1;
    check("drain", 32'(expq.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-requester arbiter and sequencer for the single-port, byte-addressed data memory.
- Port 0 is the core load/store path; port 1 is the debug/loader path.
- Per port: one request at a time, with address/size legality checks, round-robin fairness and registered responses.
- Drives the memory's address, data_in, read_write and access_size lines.
- Samples the memory's combinational data_out.

Parameters:
- BASE_ADDR, 32'h01000000, byte address of memory location 0.
- MEM_BYTES, 32'h00010000, memory size in bytes; legal range is BASE_ADDR to BASE_ADDR+MEM_BYTES-1.

Ports:
- clock  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high
- pN_req_valid  in  1  (N=0,1) request present, held until accepted
- pN_req_ready  out  1  request accepted this cycle
- pN_addr  in  32  byte address
- pN_wdata  in  32  store data, right-aligned
- pN_write  in  1  1=store, 0=load
- pN_size  in  3  access size; [1:0] 00=byte, 01=half, 10=word; [2]=1 zero-extend, 0 sign-extend
- pN_rsp_valid  out  1  one-cycle response pulse
- pN_rsp_rdata  out  32  load data, zero for stores and errors
- pN_rsp_err  out  1  request rejected, no memory access made
- mem_address  out  32  to memory address
- mem_data_in  out  32  to memory data_in
- mem_read_write  out  1  to memory read_write, 1=write
- mem_access_size  out  3  to memory access_size
- mem_data_out  in  32  from memory, combinational read
- busy  out  1  state != IDLE

Behaviour:
- Reset (async) state and outputs:
  - state=IDLE, last_grant=1 (port 0 wins the first tie).
  - All ready/rsp_valid/rsp_err=0, rsp_rdata=0, busy=0.
  - mem_read_write=0, mem_address=BASE_ADDR, mem_data_in=0, mem_access_size=3'b010.
- Memory safety: mem_read_write is 1 only during ACCESS of a legal store. A reset mid-transaction aborts it; a store never gets a second write edge.
- States: IDLE, ACCESS, RESP.
- IDLE, arbitration:
  - Only one valid port: grant it.
  - Both valid: grant !last_grant.
  - The granted pN_req_ready is high combinationally for exactly that cycle; at least one ready is high whenever any valid is high in IDLE.
  - On the edge: latch addr, wdata, write, size and port id; last_grant<=port.
  - Legality is checked on the incoming request. A legal request goes to ACCESS; an illegal one goes to RESP with err=1.
- Legality (all must hold):
  - size[1:0] != 11.
  - Half-word: addr[0]=0. Word: addr[1:0]=00.
  - BASE_ADDR <= addr and addr+bytes-1 <= BASE_ADDR+MEM_BYTES-1. Compute in 33 bits so there is no 32-bit wrap.
  - size[2] is ignored for stores.
- ACCESS (1 cycle):
  - mem_address=latched addr, mem_data_in=latched wdata, mem_access_size=latched size, mem_read_write=latched write.
  - Memory writes at the closing edge.
  - For loads, mem_data_out is captured into the response register at the closing edge.
  - Next state: RESP.
- RESP (1 cycle):
  - pN_rsp_valid=1 for the latched port only.
  - rsp_rdata = captured load data, or 0 for a store or error.
  - rsp_err as determined in IDLE.
  - Next state: IDLE. No ready is asserted in RESP.
- Latency and throughput:
  - Legal request: accept edge, then ACCESS, then rsp_valid in the 2nd cycle after acceptance.
  - Error request: rsp_valid in the 1st cycle after acceptance.
  - Maximum throughput is one legal transaction per 3 cycles.
- Responses have no backpressure; requesters must sample rsp on its pulse.
- Outside ACCESS, the mem_* outputs return to their reset values.
- A requester dropping valid before ready is a protocol violation and its effect is unspecified; the bench must not do it.

Test Plan:
- P0 stores word addr=32'h01000010 data=32'hDEADBEEF, then loads size=010 from the same address -> rsp_rdata=32'hDEADBEEF, err=0, rsp_valid 2 cycles after acceptance; mem_read_write high exactly one cycle.
- After that store: P1 loads size=000 from 32'h01000013 -> 32'hFFFFFFDE. Size=100 from the same address -> 32'h000000DE. Size=001 from 32'h01000012 -> 32'hFFFFDEAD.
- Both ports valid continuously, each issuing loads -> grants alternate P0,P1,P0,P1. The first grant after reset goes to P0. No port gets two consecutive grants while the other waits.
- Error cases, each -> err=1, rsp_rdata=0, rsp_valid 1 cycle after acceptance, mem_read_write never asserted:
  - Word load at 32'h01000002.
  - Half-word store at 32'h01000001.
  - Load at 32'h00FFFFFC.
  - Word at BASE_ADDR+MEM_BYTES-2.
  - Size=011.
- Assert reset during the ACCESS cycle of a store to 32'h01000020 -> all outputs return to reset values immediately. No rsp_valid. busy=0. Next tie goes to P0.
- Word store to the last legal word, BASE_ADDR+MEM_BYTES-4, with data 32'h12345678, read back -> err=0, data 32'h12345678.
